time_set_ctrl: RTL and testbench

Time-setting controller for the 10 MHz digital clock. It conditions the raw `prog` and `adjust` push-buttons with synchronisation and debounce. It sequences the clock through RUN / SET_SEC / SET_MIN / SET_HR and emits single-cycle increment strobes, with auto-repeat while `adjust` is held. It sits between the input switches and the time-register / display-mux datapath, replacing direct use of the button as a clock.

---
 rtl/time_set_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller: button conditioning, RUN/SET mode sequencing,
// increment strobes with auto-repeat, SET-mode timeout and field blink.

module time_set_ctrl_db #(
  parameter int unsigned CYCLES = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o
);
  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CMAX) begin
      cnt_d = '0;
      lvl_d = ~lvl_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl_o = lvl_q;
endmodule

module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned HOLD_CYCLES     = 10000000,
  parameter int unsigned REPEAT_CYCLES   = 2000000,
  parameter int unsigned TIMEOUT_S       = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_btn,
  input  logic       adj_btn,
  input  logic       tick_1s,
  output logic [1:0] mode,
  output logic       run_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hr,
  output logic       blink
);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_M1  = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_M1   = RW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_SEC = 2'd1,
    SET_MIN = 2'd2,
    SET_HR  = 2'd3
  } mode_e;

  logic prog_lvl, adj_lvl;
  logic prog_prev_q, adj_prev_q;
  logic prog_rise, adj_rise;

  mode_e         mode_q, mode_d;
  logic          lock_q, lock_d;
  logic          arm_q, arm_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [TW-1:0] to_q, to_d;
  logic          blink_q, blink_d;
  logic          run_en_q, run_en_d;
  logic [2:0]    inc_q, inc_d;

  logic in_set, timeout, mode_chg;
  logic strobe, rpt, fire;

  time_set_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
    .clk   (clk),
    .rst   (rst),
    .raw_i (prog_btn),
    .lvl_o (prog_lvl)
  );

  time_set_ctrl_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_adj (
    .clk   (clk),
    .rst   (rst),
    .raw_i (adj_btn),
    .lvl_o (adj_lvl)
  );

  assign prog_rise = prog_lvl & ~prog_prev_q;
  assign adj_rise  = adj_lvl & ~adj_prev_q;

  always_comb begin
    mode_d   = mode_q;
    lock_d   = lock_q;
    arm_d    = arm_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    to_d     = to_q;
    blink_d  = blink_q;
    strobe   = 1'b0;
    rpt      = 1'b0;
    in_set   = (mode_q != RUN);
    timeout  = in_set && (to_q == TO_MAX);
    mode_chg = prog_rise | timeout;

    if (prog_rise) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end else if (timeout) begin
      mode_d = RUN;
    end

    if (prog_rise && adj_rise) begin
      lock_d = 1'b1;
    end else if (!adj_lvl) begin
      lock_d = 1'b0;
    end

    // arm marks a hold that began with an accepted press in this mode
    if (mode_chg || !adj_lvl || lock_q || !in_set) begin
      arm_d  = 1'b0;
      hold_d = '0;
      rep_d  = '0;
    end else if (adj_rise) begin
      strobe = 1'b1;
      arm_d  = 1'b1;
      hold_d = '0;
      rep_d  = '0;
    end else if (arm_q) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
        rpt    = (hold_q == HOLD_M1);
      end else if (rep_q == REP_M1) begin
        rpt   = 1'b1;
        rep_d = '0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end

    fire     = strobe | rpt;
    inc_d[0] = fire && (mode_q == SET_SEC);
    inc_d[1] = fire && (mode_q == SET_MIN);
    inc_d[2] = fire && (mode_q == SET_HR);

    if (mode_d == RUN || mode_chg || adj_rise || rpt) begin
      to_d = '0;
    end else if (tick_1s && to_q != TO_MAX) begin
      to_d = to_q + 1'b1;
    end

    if (mode_d == RUN || mode_chg || fire) begin
      blink_d = 1'b1;
    end else if (tick_1s) begin
      blink_d = ~blink_q;
    end

    run_en_d = (mode_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_prev_q <= 1'b0;
      adj_prev_q  <= 1'b0;
      mode_q      <= RUN;
      lock_q      <= 1'b0;
      arm_q       <= 1'b0;
      hold_q      <= '0;
      rep_q       <= '0;
      to_q        <= '0;
      blink_q     <= 1'b1;
      run_en_q    <= 1'b1;
      inc_q       <= 3'b000;
    end else begin
      prog_prev_q <= prog_lvl;
      adj_prev_q  <= adj_lvl;
      mode_q      <= mode_d;
      lock_q      <= lock_d;
      arm_q       <= arm_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      to_q        <= to_d;
      blink_q     <= blink_d;
      run_en_q    <= run_en_d;
      inc_q       <= inc_d;
    end
  end

  assign mode    = mode_q;
  assign run_en  = run_en_q;
  assign inc_sec = inc_q[0];
  assign inc_min = inc_q[1];
  assign inc_hr  = inc_q[2];
  assign blink   = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: table of press/hold segments plus
// hand sequences for auto-repeat, debounce, lockout and reset.

module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       rst, prog_btn, adj_btn, tick_1s;
  logic [1:0] mode;
  logic       run_en, inc_sec, inc_min, inc_hr, blink;

  int checks = 0;
  int failures = 0;
  int ns, nm, nh;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8),
    .TIMEOUT_S       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .prog_btn (prog_btn),
    .adj_btn  (adj_btn),
    .tick_1s  (tick_1s),
    .mode     (mode),
    .run_en   (run_en),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .blink    (blink)
  );

  typedef struct {
    logic       p;
    logic       a;
    logic       t;
    int         cyc;
    logic [1:0] m;
    logic       r;
    logic       b;
    int         s;
    int         mi;
    int         h;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t V(logic p, logic a, logic t, int cyc,
                             logic [1:0] m, logic r, logic b,
                             int s, int mi, int h);
    vec_t v;
    v.p = p; v.a = a; v.t = t; v.cyc = cyc;
    v.m = m; v.r = r; v.b = b;
    v.s = s; v.mi = mi; v.h = h;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (inc_sec) ns++;
    if (inc_min) nm++;
    if (inc_hr)  nh++;
  endtask

  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr_cnt();
    ns = 0; nm = 0; nh = 0;
  endtask

  task automatic press_prog();
    prog_btn = 1'b1;
    repeat (10) step();
    prog_btn = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    int idx[$];
    int exp_idx[6];
    exp_idx = '{7, 27, 35, 43, 51, 59};
    rst = 1'b1; prog_btn = 1'b0; adj_btn = 1'b0; tick_1s = 1'b0;
    clr_cnt();
    repeat (3) step();
    chk("rst_mode", mode, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_inc", inc_sec + inc_min + inc_hr, 0);
    chk("rst_blink", blink, 1);
    rst = 1'b0;
    step();

    tv[0]  = V(1, 0, 0, 10, 1, 0, 1, 0, 0, 0);
    tv[1]  = V(0, 0, 0, 10, 1, 0, 1, 0, 0, 0);
    tv[2]  = V(1, 0, 0, 10, 2, 0, 1, 0, 0, 0);
    tv[3]  = V(0, 0, 0, 10, 2, 0, 1, 0, 0, 0);
    tv[4]  = V(0, 1, 0, 10, 2, 0, 1, 0, 1, 0);
    tv[5]  = V(0, 0, 0, 10, 2, 0, 1, 0, 0, 0);
    tv[6]  = V(1, 0, 0, 10, 3, 0, 1, 0, 0, 0);
    tv[7]  = V(0, 0, 0, 10, 3, 0, 1, 0, 0, 0);
    tv[8]  = V(1, 0, 0, 10, 0, 1, 1, 0, 0, 0);
    tv[9]  = V(0, 0, 0, 10, 0, 1, 1, 0, 0, 0);
    tv[10] = V(0, 1, 0, 10, 0, 1, 1, 0, 0, 0);
    tv[11] = V(0, 0, 0, 10, 0, 1, 1, 0, 0, 0);
    tv[12] = V(1, 0, 0, 10, 1, 0, 1, 0, 0, 0);
    tv[13] = V(0, 0, 0, 10, 1, 0, 1, 0, 0, 0);
    tv[14] = V(0, 0, 1, 5,  1, 0, 0, 0, 0, 0);
    tv[15] = V(0, 0, 1, 5,  1, 0, 1, 0, 0, 0);
    tv[16] = V(0, 0, 1, 2,  0, 1, 1, 0, 0, 0);

    for (int v = 0; v < 17; v++) begin
      clr_cnt();
      prog_btn = tv[v].p;
      adj_btn  = tv[v].a;
      for (int c = 0; c < tv[v].cyc; c++) begin
        tick_1s = tv[v].t && (c == 0);
        step();
      end
      tick_1s = 1'b0;
      chk($sformatf("v%0d_mode", v), mode, tv[v].m);
      chk($sformatf("v%0d_run_en", v), run_en, tv[v].r);
      chk($sformatf("v%0d_blink", v), blink, tv[v].b);
      chk($sformatf("v%0d_nsec", v), ns, tv[v].s);
      chk($sformatf("v%0d_nmin", v), nm, tv[v].mi);
      chk($sformatf("v%0d_nhr", v), nh, tv[v].h);
    end
    prog_btn = 1'b0; adj_btn = 1'b0;

    // auto-repeat in SET_HR
    press_prog(); press_prog(); press_prog();
    chk("ar_mode", mode, 3);
    clr_cnt();
    adj_btn = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 60) adj_btn = 1'b0;
      step();
      if (inc_hr) begin
        idx.push_back(i);
        chk("ar_blink", blink, 1);
      end
    end
    chk("ar_count", idx.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("ar_pulse%0d", k),
          (k < idx.size()) ? idx[k] : -1, exp_idx[k]);
    chk("ar_other", ns + nm, 0);
    repeat (10) step();
    press_prog();
    chk("ar_exit_mode", mode, 0);

    // debounce in SET_SEC
    press_prog();
    clr_cnt();
    for (int i = 0; i < 40; i++) begin
      adj_btn = i[1];
      step();
    end
    chk("db_glitch_nsec", ns, 0);
    adj_btn = 1'b1;
    repeat (15) step();
    adj_btn = 1'b0;
    repeat (10) step();
    chk("db_hold_nsec", ns, 1);
    chk("db_other", nm + nh, 0);
    chk("db_mode", mode, 1);
    press_prog(); press_prog(); press_prog();
    chk("db_exit_mode", mode, 0);

    // simultaneous prog+adj, then lockout
    clr_cnt();
    prog_btn = 1'b1; adj_btn = 1'b1;
    repeat (10) step();
    prog_btn = 1'b0;
    repeat (40) step();
    chk("sim_mode", mode, 1);
    chk("sim_incs", ns + nm + nh, 0);
    adj_btn = 1'b0;
    repeat (10) step();
    adj_btn = 1'b1;
    repeat (10) step();
    adj_btn = 1'b0;
    repeat (10) step();
    chk("unlock_nsec", ns, 1);

    // reset mid-hold in SET_SEC
    adj_btn = 1'b1;
    repeat (10) step();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    chk("pre_rst_blink", blink, 0);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_run_en", run_en, 1);
    chk("mid_rst_inc", inc_sec + inc_min + inc_hr, 0);
    chk("mid_rst_blink", blink, 1);
    rst = 1'b0;
    adj_btn = 1'b0;
    repeat (10) step();
    chk("post_rst_mode", mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
